// File: rtl/rv64g_instr_issue_window.sv
// Age-ordered issue window: issues the oldest entry free of register locks,
// older-entry hazards and jump barriers; 1-cycle minimum latency, no full bypass.
module rv64g_instr_issue_window #(
  parameter int DW    = 64,
  parameter int NR    = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic          clear_i,
  input  logic [DW-1:0] instr_in_i,
  input  logic [NR-1:0] instr_in_regs_i,
  input  logic          instr_in_jump_i,
  input  logic          instr_in_valid_i,
  output logic          instr_in_ready_o,
  input  logic [NR-1:0] locks_i,
  output logic [DW-1:0] instr_out_o,
  output logic [NR-1:0] instr_out_regs_o,
  output logic          instr_out_valid_o,
  input  logic          instr_out_ready_i,
  output logic [NR-1:0] lock_set_o,
  output logic [CW-1:0] count_o
);

  localparam int SW = $clog2(DEPTH);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] jmp_q, jmp_d;
  logic [DW-1:0]    dat_q  [DEPTH];
  logic [DW-1:0]    dat_d  [DEPTH];
  logic [NR-1:0]    regs_q [DEPTH];
  logic [NR-1:0]    regs_d [DEPTH];

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    wr_idx;
  logic [DEPTH-1:0] elig;
  logic [SW-1:0]    sel;
  logic             any_elig;
  logic             issue;
  logic             accept;
  logic [NR-1:0]    older_regs;
  logic             older_jmp;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) cnt = cnt + CW'(1);
    end
  end

  // An entry sees the union of all older valid entries' registers and jump flags.
  always_comb begin
    elig       = '0;
    older_regs = '0;
    older_jmp  = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      elig[k] = vld_q[k]
              && ((regs_q[k] & locks_i) == '0)
              && ((regs_q[k] & older_regs) == '0)
              && !older_jmp
              && (!jmp_q[k] || (k == 0));
      if (vld_q[k]) begin
        older_regs = older_regs | regs_q[k];
        older_jmp  = older_jmp | jmp_q[k];
      end
    end
  end

  always_comb begin
    sel      = '0;
    any_elig = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (elig[k]) begin
        sel      = SW'(k);
        any_elig = 1'b1;
      end
    end
  end

  assign instr_out_valid_o = any_elig & ~clear_i;
  assign instr_in_ready_o  = (cnt < CW'(DEPTH)) & ~clear_i;
  assign issue             = instr_out_valid_o & instr_out_ready_i;
  assign accept            = instr_in_valid_i & instr_in_ready_o;
  assign instr_out_o       = instr_out_valid_o ? dat_q[sel] : '0;
  assign instr_out_regs_o  = instr_out_valid_o ? regs_q[sel] : '0;
  assign lock_set_o        = issue ? regs_q[sel] : '0;
  assign count_o           = cnt;

  // Shift above the issued slot and write the new entry in one edge, so no hole forms.
  always_comb begin
    vld_d  = vld_q;
    jmp_d  = jmp_q;
    dat_d  = dat_q;
    regs_d = regs_q;
    wr_idx = cnt;
    if (issue) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (SW'(i) >= sel) begin
          vld_d[i]  = vld_q[i+1];
          jmp_d[i]  = jmp_q[i+1];
          dat_d[i]  = dat_q[i+1];
          regs_d[i] = regs_q[i+1];
        end
      end
      vld_d[DEPTH-1] = 1'b0;
      wr_idx         = cnt - CW'(1);
    end
    if (accept) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          vld_d[i]  = 1'b1;
          jmp_d[i]  = instr_in_jump_i;
          dat_d[i]  = instr_in_i;
          regs_d[i] = instr_in_regs_i & ~NR'(1);
        end
      end
    end
    if (clear_i) vld_d = '0;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      vld_q <= '0;
      jmp_q <= '0;
    end else begin
      vld_q <= vld_d;
      jmp_q <= jmp_d;
    end
  end

  always_ff @(posedge clk_i) begin
    dat_q  <= dat_d;
    regs_q <= regs_d;
  end

endmodule

// File: tb/tb_rv64g_instr_issue_window.sv
// Bench for rv64g_instr_issue_window: directed scenarios then random traffic,
// checked each cycle against a queue-based reference window via a scoreboard.
module tb_rv64g_instr_issue_window;

  localparam int DW    = 64;
  localparam int NR    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          arst_n;
  logic          clear;
  logic [DW-1:0] in_dat;
  logic [NR-1:0] in_regs;
  logic          in_jmp;
  logic          in_vld;
  logic          in_rdy;
  logic [NR-1:0] locks;
  logic [DW-1:0] out_dat;
  logic [NR-1:0] out_regs;
  logic          out_vld;
  logic          out_rdy;
  logic [NR-1:0] lock_set;
  logic [CW-1:0] count;

  rv64g_instr_issue_window #(.DW(DW), .NR(NR), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i             (clk),
    .arst_ni           (arst_n),
    .clear_i           (clear),
    .instr_in_i        (in_dat),
    .instr_in_regs_i   (in_regs),
    .instr_in_jump_i   (in_jmp),
    .instr_in_valid_i  (in_vld),
    .instr_in_ready_o  (in_rdy),
    .locks_i           (locks),
    .instr_out_o       (out_dat),
    .instr_out_regs_o  (out_regs),
    .instr_out_valid_o (out_vld),
    .instr_out_ready_i (out_rdy),
    .lock_set_o        (lock_set),
    .count_o           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] dat;
    logic [NR-1:0] regs;
    bit            jmp;
  } ent_t;

  typedef struct {
    bit            vld;
    logic [DW-1:0] dat;
    logic [NR-1:0] regs;
    logic [NR-1:0] lset;
    int            cnt;
    bit            rdy;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  function automatic logic [NR-1:0] rb(input int n);
    logic [NR-1:0] one;
    one = 1;
    return one << n;
  endfunction

  // Reference window: an age-ordered list, the oldest entry passing every rule is picked.
  initial begin
    forever begin
      exp_t e;
      int   sel;
      logic [NR-1:0] older;
      bit   older_jmp;
      ent_t n;
      @(negedge clk);
      if (!arst_n) mq.delete();
      sel = -1;
      older = '0;
      older_jmp = 0;
      foreach (mq[k]) begin
        if (sel < 0 && !older_jmp && (mq[k].regs & locks) == '0 &&
            (mq[k].regs & older) == '0 && (!mq[k].jmp || k == 0))
          sel = k;
        older = older | mq[k].regs;
        if (mq[k].jmp) older_jmp = 1;
      end
      e.vld  = (sel >= 0) && !clear;
      e.dat  = e.vld ? mq[sel].dat : '0;
      e.regs = e.vld ? mq[sel].regs : '0;
      e.lset = (e.vld && out_rdy) ? mq[sel].regs : '0;
      e.cnt  = mq.size();
      e.rdy  = (mq.size() < DEPTH) && !clear;
      exp_q.push_back(e);
      @(posedge clk);
      if (!arst_n || clear) begin
        mq.delete();
      end else begin
        if (e.vld && out_rdy) mq.delete(sel);
        if (in_vld && e.rdy) begin
          n.dat  = in_dat;
          n.regs = in_regs & ~rb(0);
          n.jmp  = in_jmp;
          mq.push_back(n);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL scoreboard at %0t: got no expectation expected one", $time);
      end else begin
        e = exp_q.pop_front();
        chk("count", 64'(count), 64'(e.cnt));
        chk("in_ready", 64'(in_rdy), 64'(e.rdy));
        chk("out_valid", 64'(out_vld), 64'(e.vld));
        chk("out_dat", out_dat, e.dat);
        chk("out_regs", out_regs, e.regs);
        chk("lock_set", lock_set, e.lset);
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input logic [NR-1:0] r,
                       input bit j, input logic [NR-1:0] lk, input bit ordy, input bit clr);
    in_vld  = v;
    in_dat  = d;
    in_regs = r;
    in_jmp  = j;
    locks   = lk;
    out_rdy = ordy;
    clear   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [NR-1:0] lk, input bit ordy);
    drive(0, '0, '0, 0, lk, ordy, 0);
  endtask

  initial begin
    arst_n = 1'b0;
    clear = 0; in_vld = 0; in_dat = '0; in_regs = '0; in_jmp = 0; locks = '0; out_rdy = 0;
    repeat (3) idle('0, 0);
    arst_n = 1'b1;
    idle('0, 0);

    // fill to full with ready low, try a fifth, then drain in order
    for (int i = 1; i <= 4; i++) drive(1, 64'hA0 + 64'(i), rb(i), 0, '0, 0, 0);
    drive(1, 64'hAF, rb(9), 0, '0, 0, 0);
    repeat (5) idle('0, 1);

    // locked oldest entry is bypassed
    drive(1, 64'hB5, rb(5), 0, rb(5), 0, 0);
    drive(1, 64'hB6, rb(6), 0, rb(5), 0, 0);
    idle(rb(5), 1);
    idle('0, 1);

    // same-register hazard, then jump barrier
    drive(1, 64'hC1, rb(7), 0, rb(7), 0, 0);
    drive(1, 64'hC2, rb(7) | rb(0), 0, rb(7), 0, 0);
    repeat (2) idle(rb(7), 1);
    repeat (2) idle('0, 1);
    drive(1, 64'hD1, rb(8), 1, '0, 0, 0);
    drive(1, 64'hD2, rb(9), 0, '0, 0, 0);
    repeat (3) idle('0, 1);

    // middle slot issues while a new entry is accepted
    drive(1, 64'hE1, rb(1), 0, rb(1), 0, 0);
    drive(1, 64'hE2, rb(2), 0, rb(1), 0, 0);
    drive(1, 64'hE3, rb(3), 0, rb(1), 1, 0);
    repeat (3) idle('0, 1);

    // flush with a pending input
    for (int i = 0; i < 3; i++) drive(1, 64'hF0 + 64'(i), rb(10 + i), 0, '0, 0, 0);
    drive(1, 64'hFF, rb(4), 0, '0, 1, 1);
    idle('0, 1);

    for (int c = 0; c < 3000; c++) begin
      logic [NR-1:0] r;
      logic [NR-1:0] lk;
      r = rb($urandom_range(0, 11));
      if ($urandom_range(0, 1) == 1) r = r | rb($urandom_range(0, 11));
      lk = '0;
      for (int b = 1; b < 12; b++) if ($urandom_range(0, 5) == 0) lk = lk | rb(b);
      arst_n = ($urandom_range(0, 299) != 0);
      drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, r, $urandom_range(0, 7) == 0,
            lk, $urandom_range(0, 9) < 7, $urandom_range(0, 59) == 0);
      arst_n = 1'b1;
    end
    idle('0, 0);
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
